// File: rtl/i2c_pkg.sv
// Shared definitions for the multi-byte I2C secondary.
//   i2c_state_t   : protocol FSM states
//   RW_READ       : value of the R/W bit that selects a read
//   ACK / NACK    : SDA level for acknowledge / not-acknowledge
//   BITS_PER_BYTE : data bits per byte on the wire
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK,
    WAIT_STOP
  } i2c_state_t;

  localparam logic RW_READ       = 1'b1;
  localparam logic ACK           = 1'b0;
  localparam logic NACK          = 1'b1;
  localparam int   BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_secondary_multibyte_if.sv
// Open-drain I2C bus as seen by one primary and one secondary.
//   SCL     : bus clock, driven by the primary
//   SDA_OUT : primary SDA drive (0 = pull low)
//   SDA_OE  : primary output enable, informational only
//   SDA_IN  : secondary SDA drive (1 = release, 0 = pull low)
// Effective bus SDA is SDA_OUT & SDA_IN.
interface i2c_secondary_multibyte_if;
  logic SCL;
  logic SDA_OUT;
  logic SDA_OE;
  logic SDA_IN;

  modport master (output SCL, output SDA_OUT, output SDA_OE, input SDA_IN);
  modport slave  (input SCL, input SDA_OUT, input SDA_OE, output SDA_IN);
endinterface

// File: rtl/i2c_bus_cond_detect.sv
// SCL/SDA history registers and bus-condition decode.
//   CLK, RESET : system clock, synchronous active-low reset
//   scl        : bus clock
//   sda_bus    : resolved bus SDA
//   scl_rise, scl_fall   : single-cycle SCL edge flags
//   start_det, stop_det  : SDA falling / rising while SCL stays high
module i2c_bus_cond_detect (
  input  logic CLK,
  input  logic RESET,
  input  logic scl,
  input  logic sda_bus,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);
  logic scl_q;
  logic sda_q;

  // History resets to an idle (released) bus so leaving reset never looks like an edge.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl;
      sda_q <= sda_bus;
    end
  end

  assign scl_rise  = scl & ~scl_q;
  assign scl_fall  = ~scl & scl_q;
  assign start_det = scl & scl_q & sda_q & ~sda_bus;
  assign stop_det  = scl & scl_q & ~sda_q & sda_bus;
endmodule

// File: rtl/i2c_secondary_multibyte.sv
// I2C secondary with DATA_BYTES-byte register write and read transfers.
//   CLK, RESET : system clock, synchronous active-low reset
//   bus        : I2C bus (slave modport), SDA_IN is registered
//   I2CS_ADDR  : this secondary's 7-bit address
//   RD_DATA    : read payload, snapshotted at the address ACK, MSB byte first
//   WR_DATA    : last complete write payload, first byte received is MSB byte
//   WR_VALID   : one-cycle pulse when WR_DATA updates
//   BUSY       : high from address match until START, STOP or mismatch
module i2c_secondary_multibyte
  import i2c_pkg::*;
#(
  parameter int DATA_BYTES = 2,
  parameter int ADDR_W     = 7
) (
  input  logic                    CLK,
  input  logic                    RESET,
  i2c_secondary_multibyte_if.slave bus,
  input  logic [ADDR_W-1:0]       I2CS_ADDR,
  input  logic [8*DATA_BYTES-1:0] RD_DATA,
  output logic [8*DATA_BYTES-1:0] WR_DATA,
  output logic                    WR_VALID,
  output logic                    BUSY
);
  localparam int PAY_W = 8 * DATA_BYTES;
  localparam int IDX_W = $clog2(DATA_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);
  localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(DATA_BYTES);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
  localparam logic [3:0]       LAST_BIT = 4'(BITS_PER_BYTE - 1);
  localparam logic [3:0]       ACK_BIT  = 4'(BITS_PER_BYTE);

  i2c_state_t        state_q, state_d;
  logic [3:0]        bit_q, bit_d;
  logic [IDX_W-1:0]  byte_q, byte_d;
  logic [7:0]        shift_q, shift_d, shifted;
  logic [PAY_W-1:0]  staging_q, staging_d;
  logic [PAY_W-1:0]  snap_q, snap_d;
  logic [PAY_W-1:0]  wr_data_q, wr_data_d;
  logic              sda_q, sda_d;
  logic              wr_valid_q, wr_valid_d;
  logic              busy_q, busy_d;
  logic              sda_bus, scl_rise, scl_fall, start_det, stop_det;
  logic              unused_oe;

  assign sda_bus    = bus.SDA_OUT & sda_q;
  assign bus.SDA_IN = sda_q;
  assign WR_DATA    = wr_data_q;
  assign WR_VALID   = wr_valid_q;
  assign BUSY       = busy_q;
  assign unused_oe  = bus.SDA_OE;

  i2c_bus_cond_detect u_cond (
    .CLK       (CLK),
    .RESET     (RESET),
    .scl       (bus.SCL),
    .sda_bus   (sda_bus),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  // Snapshot bit for byte byte_i, bit bit_i (bit 0 = MSB of that byte).
  function automatic logic read_bit(input logic [PAY_W-1:0] snap,
                                    input logic [IDX_W-1:0] byte_i,
                                    input logic [3:0]       bit_i);
    logic [PAY_W-1:0] sh;
    sh = snap >> (BITS_PER_BYTE * (DATA_BYTES - int'(byte_i)) - 1 - int'(bit_i));
    return sh[0];
  endfunction

  // Replace byte slot idx (slot 0 = MSB byte) of old_v with b.
  function automatic logic [PAY_W-1:0] put_byte(input logic [PAY_W-1:0] old_v,
                                                input logic [IDX_W-1:0] idx,
                                                input logic [7:0]       b);
    int sh;
    sh = BITS_PER_BYTE * (DATA_BYTES - 1 - int'(idx));
    return (old_v & ~(PAY_W'(8'hFF) << sh)) | (PAY_W'(b) << sh);
  endfunction

  assign shifted = {shift_q[6:0], sda_bus};

  // Ack states are entered at the 8th SCL rise with bit counter = 8; the 9th rise
  // clears it to 0, which tells the two SCL falls of the ack window apart.
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    shift_d    = shift_q;
    staging_d  = staging_q;
    snap_d     = snap_q;
    wr_data_d  = wr_data_q;
    sda_d      = sda_q;
    wr_valid_d = 1'b0;
    busy_d     = busy_q;
    if (start_det) begin
      state_d = ADDR;
      bit_d   = 4'd0;
      byte_d  = '0;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
    end else if (stop_det) begin
      state_d = IDLE;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d = shifted;
          if (bit_q == LAST_BIT) begin
            bit_d = ACK_BIT;
            if (shifted[7:1] == I2CS_ADDR) begin
              state_d = ADDR_ACK;
              busy_d  = 1'b1;
            end else begin
              state_d = WAIT_STOP;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
        ADDR_ACK: begin
          if (scl_fall && bit_q == ACK_BIT) begin
            sda_d = ACK;
          end else if (scl_rise) begin
            bit_d = 4'd0;
            if (shift_q[0] == RW_READ) snap_d = RD_DATA;
          end else if (scl_fall) begin
            if (shift_q[0] == RW_READ) begin
              state_d = READ;
              sda_d   = read_bit(snap_q, byte_q, 4'd0);
            end else begin
              state_d = WRITE;
              sda_d   = 1'b1;
            end
          end
        end
        WRITE: if (scl_rise) begin
          shift_d = shifted;
          if (bit_q == LAST_BIT) begin
            bit_d   = ACK_BIT;
            state_d = WRITE_ACK;
            if (byte_q < FULL_IDX) staging_d = put_byte(staging_q, byte_q, shifted);
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
        WRITE_ACK: begin
          if (scl_fall && bit_q == ACK_BIT) begin
            sda_d = (byte_q < FULL_IDX) ? ACK : NACK;
          end else if (scl_rise) begin
            bit_d = 4'd0;
          end else if (scl_fall) begin
            sda_d   = 1'b1;
            state_d = WRITE;
            if (byte_q == LAST_IDX) begin
              wr_data_d  = staging_q;
              wr_valid_d = 1'b1;
            end
            if (byte_q < FULL_IDX) byte_d = byte_q + ONE_IDX;
          end
        end
        READ: if (scl_fall) begin
          if (bit_q == LAST_BIT) begin
            sda_d   = 1'b1;
            bit_d   = ACK_BIT;
            state_d = READ_ACK;
          end else begin
            bit_d = bit_q + 4'd1;
            sda_d = read_bit(snap_q, byte_q, bit_q + 4'd1);
          end
        end
        READ_ACK: begin
          if (scl_rise) begin
            if (sda_bus == ACK) begin
              bit_d  = 4'd0;
              byte_d = (byte_q == LAST_IDX) ? '0 : byte_q + ONE_IDX;
            end else begin
              state_d = WAIT_STOP;
            end
          end else if (scl_fall && bit_q == 4'd0) begin
            state_d = READ;
            sda_d   = read_bit(snap_q, byte_q, 4'd0);
          end
        end
        default: sda_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= IDLE;
      bit_q      <= 4'd0;
      byte_q     <= '0;
      shift_q    <= 8'd0;
      staging_q  <= '0;
      snap_q     <= '0;
      wr_data_q  <= '0;
      sda_q      <= 1'b1;
      wr_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      shift_q    <= shift_d;
      staging_q  <= staging_d;
      snap_q     <= snap_d;
      wr_data_q  <= wr_data_d;
      sda_q      <= sda_d;
      wr_valid_q <= wr_valid_d;
      busy_q     <= busy_d;
    end
  end
endmodule

// File: tb/tb_i2c_secondary_multibyte.sv
module tb_i2c_secondary_multibyte;
  localparam int DB   = 2;
  localparam int PW   = 8 * DB;
  localparam int HALF = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [6:0]    my_addr;
  logic [PW-1:0] rd_data;
  logic [PW-1:0] wr_data;
  logic          wr_valid;
  logic          busy;

  i2c_secondary_multibyte_if bus ();

  i2c_secondary_multibyte #(.DATA_BYTES(DB), .ADDR_W(7)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .bus       (bus),
    .I2CS_ADDR (my_addr),
    .RD_DATA   (rd_data),
    .WR_DATA   (wr_data),
    .WR_VALID  (wr_valid),
    .BUSY      (busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic          exp_sda[$];
  logic [PW-1:0] exp_wr[$];
  logic [7:0]    tx_bytes[$];
  logic [PW-1:0] model_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Monitor: pops expected SDA level at every SCL rise, checks it holds through
  // the high phase, and pops an expected payload for every WR_VALID cycle.
  logic scl_prev = 1'b1;
  logic sda_at_rise = 1'b1;
  always @(negedge CLK) begin
    if (bus.SCL && !scl_prev) begin
      if (exp_sda.size() == 0) fail("sda_unexpected_rise");
      else chk("sda_at_rise", 32'(bus.SDA_IN), 32'(exp_sda.pop_front()));
      sda_at_rise = bus.SDA_IN;
    end
    if (!bus.SCL && scl_prev) chk("sda_stable_high", 32'(bus.SDA_IN), 32'(sda_at_rise));
    scl_prev = bus.SCL;
    if (wr_valid === 1'b1) begin
      if (exp_wr.size() == 0) fail("wr_valid_unexpected");
      else chk("wr_data_at_valid", 32'(wr_data), 32'(exp_wr.pop_front()));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic start_cond();
    if (!bus.SCL) begin
      bus.SDA_OUT = 1'b1;
      tick(2);
      exp_sda.push_back(1'b1);
      bus.SCL = 1'b1;
      tick(HALF);
    end
    bus.SDA_OUT = 1'b0;
    tick(HALF);
    bus.SCL = 1'b0;
    tick(2);
  endtask

  task automatic stop_cond();
    bus.SDA_OUT = 1'b0;
    tick(2);
    exp_sda.push_back(1'b1);
    bus.SCL = 1'b1;
    tick(HALF);
    bus.SDA_OUT = 1'b1;
    tick(HALF);
  endtask

  task automatic clock_bit(input logic drive, input logic exp_in);
    bus.SDA_OUT = drive;
    tick(2);
    exp_sda.push_back(exp_in);
    bus.SCL = 1'b1;
    tick(HALF);
    bus.SCL = 1'b0;
    tick(2);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack);
    for (int i = 7; i >= 0; i--) clock_bit(b[i], 1'b1);
    clock_bit(1'b1, exp_ack);
  endtask

  task automatic recv_byte(input logic [7:0] exp_b, input logic primary_ack);
    for (int i = 7; i >= 0; i--) clock_bit(1'b1, exp_b[i]);
    clock_bit(primary_ack, 1'b1);
  endtask

  // Write tx_bytes to address a. A matched write of at least DB bytes publishes
  // the first DB bytes (first byte most significant); later bytes are refused.
  task automatic write_txn(input logic [6:0] a, input logic rep_start);
    logic          match;
    logic [PW-1:0] payload;
    match   = (a == my_addr);
    payload = '0;
    start_cond();
    send_byte({a, 1'b0}, match ? 1'b0 : 1'b1);
    chk("busy_after_addr_wr", 32'(busy), 32'(match));
    for (int k = 0; k < tx_bytes.size(); k++) begin
      if (k < DB) payload = (payload << 8) | PW'(tx_bytes[k]);
      if (match && k == DB - 1) begin
        exp_wr.push_back(payload);
        model_wr = payload;
      end
      send_byte(tx_bytes[k], (match && k < DB) ? 1'b0 : 1'b1);
    end
    if (!rep_start) begin
      stop_cond();
      chk("busy_after_stop_wr", 32'(busy), 32'd0);
    end
  endtask

  // Read n bytes; primary ACKs all but the last. Data comes from RD_DATA as it
  // stood at the address phase, byte k = slot k mod DB; RD_DATA is scrambled after.
  task automatic read_txn(input logic [6:0] a, input int n, input logic rep_start);
    logic          match;
    logic [PW-1:0] snap;
    logic [7:0]    eb;
    match = (a == my_addr);
    snap  = rd_data;
    start_cond();
    send_byte({a, 1'b1}, match ? 1'b0 : 1'b1);
    chk("busy_after_addr_rd", 32'(busy), 32'(match));
    rd_data = PW'($urandom);
    for (int k = 0; k < n; k++) begin
      eb = match ? snap[8 * (DB - 1 - (k % DB)) +: 8] : 8'hFF;
      recv_byte(eb, (k == n - 1) ? 1'b1 : 1'b0);
    end
    chk("busy_before_end_rd", 32'(busy), 32'(match));
    if (!rep_start) begin
      stop_cond();
      chk("busy_after_stop_rd", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    logic [6:0] a;
    int         n;
    bus.SCL     = 1'b1;
    bus.SDA_OUT = 1'b1;
    bus.SDA_OE  = 1'b1;
    my_addr     = 7'h5A;
    rd_data     = 16'h1234;
    model_wr    = '0;
    RESET       = 1'b0;
    tick(3);
    chk("reset_sda_in", 32'(bus.SDA_IN), 32'd1);
    chk("reset_wr_data", 32'(wr_data), 32'd0);
    chk("reset_wr_valid", 32'(wr_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    RESET = 1'b1;
    tick(4);

    tx_bytes = '{8'hBE, 8'hEF};
    write_txn(7'h5A, 1'b0);
    chk("wr_beef", 32'(wr_data), 32'h0000BEEF);

    rd_data = 16'h1234;
    read_txn(7'h5A, 2, 1'b0);

    tx_bytes = '{8'h12, 8'h34};
    write_txn(7'h33, 1'b0);
    chk("wr_after_mismatch", 32'(wr_data), 32'h0000BEEF);

    tx_bytes = '{8'h11, 8'h22, 8'h33};
    write_txn(7'h5A, 1'b0);
    chk("wr_overlong", 32'(wr_data), 32'h00001122);

    tx_bytes = '{8'hAA};
    write_txn(7'h5A, 1'b1);
    rd_data = 16'hA5C3;
    read_txn(7'h5A, 3, 1'b0);
    chk("wr_after_partial", 32'(wr_data), 32'h00001122);

    // Reset in the high phase of the 5th address bit.
    start_cond();
    for (int i = 7; i > 3; i--) clock_bit(my_addr[i - 1], 1'b1);
    bus.SDA_OUT = my_addr[2];
    tick(2);
    exp_sda.push_back(1'b1);
    bus.SCL = 1'b1;
    tick(2);
    RESET = 1'b0;
    tick(1);
    RESET = 1'b1;
    chk("abort_sda_in", 32'(bus.SDA_IN), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wr_data", 32'(wr_data), 32'd0);
    model_wr = '0;
    bus.SDA_OUT = 1'b1;
    tick(HALF);
    tx_bytes = '{8'hCA, 8'hFE};
    write_txn(7'h5A, 1'b0);
    chk("wr_cafe", 32'(wr_data), 32'h0000CAFE);

    for (int t = 0; t < 30; t++) begin
      a = ($urandom_range(0, 3) == 0) ? (my_addr ^ 7'($urandom_range(1, 127))) : my_addr;
      n = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) begin
        tx_bytes = {};
        for (int k = 0; k < n; k++) tx_bytes.push_back(8'($urandom));
        write_txn(a, 1'($urandom_range(0, 1)));
      end else begin
        rd_data = PW'($urandom);
        read_txn(a, n, 1'($urandom_range(0, 1)));
      end
      chk("wr_data_hold", 32'(wr_data), 32'(model_wr));
    end
    if (!bus.SCL) stop_cond();
    tick(8);
    chk("exp_sda_drained", 32'(exp_sda.size()), 32'd0);
    chk("exp_wr_drained", 32'(exp_wr.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
